// File: rtl/divider_floor_adjust.sv
// divider_floor_adjust
//
// Converts the truncated quotient/remainder pairs from the signed integer
// divider into floored (modulo) form, so the remainder takes the sign of the
// divisor. The divider does not pass the divisor through, so each divisor is
// captured on a side handshake and queued in an in-order FIFO. Every result
// handshake pops exactly one divisor. The corrected word is presented through
// a two-entry registered skid buffer.
//
// Ports
//   clock               rising-edge clock for all state
//   clear_n             asynchronous active-low reset
//   divisor_valid/ready side-channel divisor push (ready = FIFO not full)
//   divisor_in          signed divisor, WORD_WIDTH bits
//   result_valid/ready  divider result handshake (ready = divisor queued
//                       and skid buffer not full)
//   quotient_in         truncated quotient from the divider
//   remainder_in        truncated remainder from the divider
//   divide_by_zero_in   divider's divide-by-zero flag
//   output_valid/ready  output handshake
//   quotient, remainder floored results (registered)
//   divide_by_zero      divide-by-zero flag passed through
//   adjusted            1 when a floor correction was applied
//
// Every output comes straight from a register. divisor_ready, result_ready
// and output_valid are decoded only from registered state, so there is no
// combinational path from any input valid, or from output_ready, to an
// output.

module divider_floor_adjust #(
  parameter int WORD_WIDTH = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  clear_n,
  // divisor side channel
  input  logic                  divisor_valid,
  output logic                  divisor_ready,
  input  logic [WORD_WIDTH-1:0] divisor_in,
  // divider results
  input  logic                  result_valid,
  output logic                  result_ready,
  input  logic [WORD_WIDTH-1:0] quotient_in,
  input  logic [WORD_WIDTH-1:0] remainder_in,
  input  logic                  divide_by_zero_in,
  // floored output
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [WORD_WIDTH-1:0] quotient,
  output logic [WORD_WIDTH-1:0] remainder,
  output logic                  divide_by_zero,
  output logic                  adjusted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------
  // Divisor FIFO
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] head_divisor;

  // When the FIFO is full, divisor_ready is low, so a push is refused even
  // if a pop happens in the same cycle. When the FIFO is empty,
  // result_ready is low, so a divisor pushed this cycle cannot be used
  // until the next cycle. Neither case bypasses the FIFO.
  assign divisor_ready = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push          = divisor_valid & divisor_ready;
  assign pop           = result_valid & result_ready;
  assign head_divisor  = fifo_mem[rd_ptr_reg];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is left unreset. A reset clears the pointers and the count,
  // so stale entries can never be read.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= divisor_in;
  end

  // ---------------------------------------------------------------------
  // Floor adjustment
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [WORD_WIDTH-1:0] quot;
    logic [WORD_WIDTH-1:0] rem;
    logic                  dbz;
    logic                  adj;
  } out_word_t;

  logic      needs_fix;
  out_word_t word_next;

  // A nonzero remainder whose sign differs from the divisor's sign is
  // where truncation and floor rounding disagree. In that case the
  // quotient moves down by one and the remainder moves by one divisor.
  assign needs_fix = ~divide_by_zero_in
                   & (remainder_in != '0)
                   & (remainder_in[WORD_WIDTH-1] != head_divisor[WORD_WIDTH-1]);

  always_comb begin
    word_next.quot = quotient_in;
    word_next.rem  = remainder_in;
    word_next.dbz  = divide_by_zero_in;
    word_next.adj  = needs_fix;
    if (needs_fix) begin
      // Adding all-ones is the same as subtracting one modulo 2^WORD_WIDTH,
      // so the most-negative quotient wraps to the most-positive value.
      word_next.quot = quotient_in + '1;
      word_next.rem  = remainder_in + head_divisor;
    end
  end

  // ---------------------------------------------------------------------
  // Output skid buffer
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  skid_state_t state_reg;
  out_word_t   main_reg;
  out_word_t   skid_reg;
  logic        out_fire;

  assign output_valid = (state_reg != SKID_EMPTY);
  assign result_ready = (count_reg != '0) & (state_reg != SKID_FULL);
  assign out_fire     = output_valid & output_ready;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= SKID_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      case (state_reg)
        SKID_EMPTY: begin
          if (pop) begin
            main_reg  <= word_next;
            state_reg <= SKID_BUSY;
          end
        end
        SKID_BUSY: begin
          if (pop && out_fire) begin
            main_reg <= word_next;
          end else if (pop) begin
            // The output is stalled, so the new word goes to the skid
            // register. Main stays stable.
            skid_reg  <= word_next;
            state_reg <= SKID_FULL;
          end else if (out_fire) begin
            state_reg <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (out_fire) begin
            main_reg  <= skid_reg;
            state_reg <= SKID_BUSY;
          end
        end
        default: state_reg <= SKID_EMPTY;
      endcase
    end
  end

  assign quotient       = main_reg.quot;
  assign remainder      = main_reg.rem;
  assign divide_by_zero = main_reg.dbz;
  assign adjusted       = main_reg.adj;

endmodule

// File: tb/tb_divider_floor_adjust.sv
// Self-checking bench for divider_floor_adjust (WORD_WIDTH=8, FIFO_DEPTH=4).
// The reference model works from the original dividend: n = q*d + r.
// It takes the real floor of n/d, reduces the result modulo 2^8, and
// uses queues to track the divisors and outputs that should be in flight.
module tb_divider_floor_adjust;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         divisor_valid = 1'b0;
  logic         divisor_ready;
  logic [W-1:0] divisor_in = '0;
  logic         result_valid = 1'b0;
  logic         result_ready;
  logic [W-1:0] quotient_in = '0;
  logic [W-1:0] remainder_in = '0;
  logic         divide_by_zero_in = 1'b0;
  logic         output_valid;
  logic         output_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divide_by_zero;
  logic         adjusted;

  always #5 clock = ~clock;

  divider_floor_adjust #(.WORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .clear_n(clear_n),
    .divisor_valid(divisor_valid), .divisor_ready(divisor_ready), .divisor_in(divisor_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .quotient_in(quotient_in), .remainder_in(remainder_in),
    .divide_by_zero_in(divide_by_zero_in),
    .output_valid(output_valid), .output_ready(output_ready),
    .quotient(quotient), .remainder(remainder),
    .divide_by_zero(divide_by_zero), .adjusted(adjusted)
  );

  typedef struct packed { int q; int r; int dbz; int adj; } res_t;

  int   checks = 0;
  int   errors = 0;
  int   m_div[$];     // divisors the DUT should hold
  res_t m_exp[$];     // outputs the DUT should present, in order
  res_t obs[$];       // outputs observed at output handshakes
  time  obs_t[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap8(int x);
    logic [7:0] b;
    b = x[7:0];
    return int'($signed(b));
  endfunction

  // Floored division of the reconstructed dividend.
  function automatic res_t model(int q, int r, int d, int dbz);
    res_t o;
    int n, fq, fr;
    if (dbz != 0) begin
      o.q = q; o.r = r; o.dbz = 1; o.adj = 0;
      return o;
    end
    n  = q * d + r;
    fq = $rtoi($floor(real'(n) / real'(d)));
    fr = n - fq * d;
    o.q = wrap8(fq); o.r = wrap8(fr); o.dbz = 0;
    o.adj = (fq != q) ? 1 : 0;
    return o;
  endfunction

  // Compare process. At each negedge it checks the DUT against the model,
  // then advances the model by the handshakes that the next posedge will
  // complete.
  always @(negedge clock) begin
    res_t e, cur;
    int d;
    if (!clear_n) begin
      m_div.delete();
      m_exp.delete();
      chk("rst_output_valid", int'(output_valid), 0);
      chk("rst_result_ready", int'(result_ready), 0);
      chk("rst_divisor_ready", int'(divisor_ready), 1);
      chk("rst_data", int'({quotient, remainder, divide_by_zero, adjusted}), 0);
    end else begin
      chk("output_valid", int'(output_valid), (m_exp.size() != 0) ? 1 : 0);
      chk("divisor_ready", int'(divisor_ready), (m_div.size() < DEPTH) ? 1 : 0);
      chk("result_ready", int'(result_ready),
          (m_div.size() != 0 && m_exp.size() < 2) ? 1 : 0);
      cur.q = int'($signed(quotient)); cur.r = int'($signed(remainder));
      cur.dbz = int'(divide_by_zero); cur.adj = int'(adjusted);
      if (output_valid && m_exp.size() != 0) begin
        chk("quotient", cur.q, m_exp[0].q);
        chk("remainder", cur.r, m_exp[0].r);
        chk("divide_by_zero", cur.dbz, m_exp[0].dbz);
        chk("adjusted", cur.adj, m_exp[0].adj);
      end
      if (output_valid && output_ready) begin
        obs.push_back(cur);
        obs_t.push_back($time);
        if (m_exp.size() != 0) void'(m_exp.pop_front());
      end
      if (result_valid && result_ready) begin
        if (m_div.size() == 0) begin
          chk("accept_without_divisor", 1, 0);
        end else begin
          d = m_div.pop_front();
          e = model(int'($signed(quotient_in)), int'($signed(remainder_in)), d,
                    int'(divide_by_zero_in));
          m_exp.push_back(e);
        end
      end
      if (divisor_valid && divisor_ready) m_div.push_back(int'($signed(divisor_in)));
    end
  end

  task automatic push_div(int d);
    bit hs = 0;
    divisor_valid = 1'b1;
    divisor_in = d[7:0];
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clock);
      hs = divisor_ready;
      @(posedge clock); #1;
    end
    divisor_valid = 1'b0;
    if (!hs) chk("push_timeout", 0, 1);
  endtask

  task automatic feed(int q, int r, int dbz);
    bit hs = 0;
    result_valid = 1'b1;
    quotient_in = q[7:0];
    remainder_in = r[7:0];
    divide_by_zero_in = dbz[0];
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clock);
      hs = result_ready;
      @(posedge clock); #1;
    end
    result_valid = 1'b0;
    if (!hs) chk("feed_timeout", 0, 1);
  endtask

  // Feeds the truncated quotient/remainder of a/d.
  task automatic feed_a(int a, int d);
    feed(a / d, a % d, 0);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_obs(string name, int idx, int q, int r, int dbz, int adj);
    if (idx >= obs.size()) begin
      chk({name, "_missing"}, obs.size(), idx + 1);
    end else begin
      chk({name, "_q"}, obs[idx].q, q);
      chk({name, "_r"}, obs[idx].r, r);
      chk({name, "_dbz"}, obs[idx].dbz, dbz);
      chk({name, "_adj"}, obs[idx].adj, adj);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int eq[5] = '{3, -4, -4, 3, -3};
    int er[5] = '{1, 6, -6, -1, 0};
    int ea[5] = '{0, 1, 1, 0, 0};
    int drv_div[$];
    bit res_pending;
    bit hs_push, hs_acc;
    logic [7:0] rb;
    int d, a;

    // Reset state
    @(posedge clock); #1;
    chk("reset_divisor_ready", int'(divisor_ready), 1);
    chk("reset_result_ready", int'(result_ready), 0);
    chk("reset_output_valid", int'(output_valid), 0);
    @(posedge clock); #1;
    clear_n = 1'b1;
    output_ready = 1'b1;

    // Signed cases
    base = obs.size();
    push_div(7); push_div(7); push_div(-7); push_div(-7);
    feed(3, 1, 0);
    push_div(7);
    feed(-3, -1, 0); feed(-3, 1, 0); feed(3, -1, 0); feed(-3, 0, 0);
    idle(4);
    chk("signed_count", obs.size() - base, 5);
    for (int i = 0; i < 5; i++) chk_obs("signed", base + i, eq[i], er[i], 0, ea[i]);

    // Divide by zero
    base = obs.size();
    push_div(0);
    feed(-1, 22, 1);
    idle(3);
    chk_obs("dbz", base, -1, 22, 1, 0);
    @(negedge clock);
    chk("dbz_fifo_empty_result_ready", int'(result_ready), 0);
    chk("dbz_fifo_empty_divisor_ready", int'(divisor_ready), 1);
    @(posedge clock); #1;

    // Backpressure
    output_ready = 1'b0;
    push_div(5); push_div(5); push_div(5);
    base = obs.size();
    feed(1, 2, 0);
    feed(-1, -2, 0);
    result_valid = 1'b1; quotient_in = 8'd2; remainder_in = 8'd0; divide_by_zero_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_result_ready_low", int'(result_ready), 0);
      chk("bp_hold_q", int'($signed(quotient)), 1);
      chk("bp_hold_r", int'($signed(remainder)), 2);
    end
    @(posedge clock); #1;
    output_ready = 1'b1;
    begin
      bit hs = 0;
      for (int i = 0; i < 20 && !hs; i++) begin
        @(negedge clock); hs = result_ready; @(posedge clock); #1;
      end
      if (!hs) chk("bp_third_timeout", 0, 1);
    end
    result_valid = 1'b0;
    idle(4);
    chk("bp_count", obs.size() - base, 3);
    chk_obs("bp0", base, 1, 2, 0, 0);
    chk_obs("bp1", base + 1, -2, 3, 0, 1);
    chk_obs("bp2", base + 2, 2, 0, 0, 0);
    if (obs.size() >= base + 3) begin
      chk("bp_spacing01", int'(obs_t[base + 1] - obs_t[base]), 10);
      chk("bp_spacing12", int'(obs_t[base + 2] - obs_t[base + 1]), 10);
    end

    // FIFO limits
    push_div(1); push_div(2); push_div(3); push_div(4);
    divisor_valid = 1'b1; divisor_in = 8'd9;
    @(negedge clock);
    chk("full_divisor_ready", int'(divisor_ready), 0);
    @(posedge clock); #1;
    result_valid = 1'b1; quotient_in = 8'd5; remainder_in = 8'd0; divide_by_zero_in = 1'b0;
    @(negedge clock);
    chk("full_pop_push_refused", int'(divisor_ready), 0);
    chk("full_pop_result_ready", int'(result_ready), 1);
    @(posedge clock); #1;
    divisor_valid = 1'b0; result_valid = 1'b0;
    @(negedge clock);
    chk("after_pop_divisor_ready", int'(divisor_ready), 1);
    @(posedge clock); #1;
    feed_a(-7, 2); feed_a(-9, 3); feed_a(10, 4);
    @(negedge clock);
    chk("empty_result_ready", int'(result_ready), 0);
    @(posedge clock); #1;
    idle(3);

    // Wrap
    base = obs.size();
    push_div(127);
    feed(-128, -1, 0);
    idle(3);
    chk_obs("wrap", base, 127, 126, 0, 1);

    // Async reset mid-stream, with the skid buffer FULL and 3 divisors queued
    output_ready = 1'b0;
    push_div(3); push_div(3); push_div(3); push_div(3);
    feed_a(10, 3); feed_a(-10, 3);
    push_div(3);
    @(posedge clock); #3;
    clear_n = 1'b0;
    #1;
    chk("arst_output_valid", int'(output_valid), 0);
    chk("arst_result_ready", int'(result_ready), 0);
    chk("arst_divisor_ready", int'(divisor_ready), 1);
    chk("arst_quotient", int'(quotient), 0);
    chk("arst_remainder", int'(remainder), 0);
    chk("arst_flags", int'({divide_by_zero, adjusted}), 0);
    repeat (2) @(posedge clock);
    #1;
    clear_n = 1'b1;
    output_ready = 1'b1;
    base = obs.size();
    push_div(7);
    feed(-2, -6, 0);
    idle(3);
    chk("arst_fresh_count", obs.size() - base, 1);
    chk_obs("arst_fresh", base, -3, 1, 0, 1);

    // Randomized traffic
    res_pending = 0;
    for (int i = 0; i < 400; i++) begin
      rb = 8'($urandom);
      d = int'($signed(rb));
      if ($urandom_range(0, 9) == 0) d = 0;
      divisor_valid = ($urandom_range(0, 2) != 0);
      divisor_in = d[7:0];
      if (!res_pending && drv_div.size() != 0 && $urandom_range(0, 1) == 1) begin
        res_pending = 1;
        result_valid = 1'b1;
        if (drv_div[0] == 0) begin
          quotient_in = 8'($urandom);
          remainder_in = 8'($urandom);
          divide_by_zero_in = 1'b1;
        end else begin
          rb = 8'($urandom);
          a = int'($signed(rb));
          if (a == -128 && drv_div[0] == -1) a = -127;
          quotient_in = 8'(a / drv_div[0]);
          remainder_in = 8'(a % drv_div[0]);
          divide_by_zero_in = 1'b0;
        end
      end
      output_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      hs_push = divisor_valid && divisor_ready;
      hs_acc = result_valid && result_ready;
      @(posedge clock); #1;
      if (hs_push) drv_div.push_back(int'($signed(divisor_in)));
      if (hs_acc) begin
        void'(drv_div.pop_front());
        res_pending = 0;
        result_valid = 1'b0;
      end
    end
    divisor_valid = 1'b0;
    result_valid = 1'b0;
    output_ready = 1'b1;
    idle(10);
    chk("random_drained", m_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_floor_adjust.md
# divider_floor_adjust

Downstream companion to the signed integer divider. The divider produces truncated quotient/remainder pairs; this block converts them to floored (modulo) semantics, so the remainder takes the sign of the divisor. It needs each operation's divisor, which it captures through a side handshake fired in parallel with the divider's input handshake. Divisors are held in an internal in-order FIFO, paired with divider results, adjusted, and presented through a registered skid output.

## Interface

- `WORD_WIDTH`, default 0: integer width; must be overridden, ≥2; equals the divider's `WORD_WIDTH`.
- `FIFO_DEPTH`, default 4: divisor FIFO entries, power of two, ≥2; must be ≥ the divider's maximum in-flight operations.
- `clock` in 1: single clock, all logic rising-edge.
- `clear_n` in 1: **asynchronous, active-low reset**.
- `divisor_valid` in 1: side-channel divisor offered; fired in parallel with the divider input handshake.
- `divisor_ready` out 1: FIFO not full.
- `divisor_in` in `WORD_WIDTH`: signed divisor.
- `result_valid` in 1: divider output valid.
- `result_ready` out 1: result accepted.
- `quotient_in`, `remainder_in` in `WORD_WIDTH`: truncated results.
- `divide_by_zero_in` in 1: divider flag.
- `output_valid` out 1, `output_ready` in 1: output handshake.
- `quotient`, `remainder` out `WORD_WIDTH`: floored results.
- `divide_by_zero` out 1: passed through.
- `adjusted` out 1: 1 when a correction was applied.

## Operation

- Divisor FIFO: a circular buffer with read/write pointers and a count of width log2(`FIFO_DEPTH`)+1.
  - Push on `divisor_valid & divisor_ready`; `divisor_ready = (count != FIFO_DEPTH)`, from registered state only.
  - Full with a simultaneous pop: push is refused that cycle, with no bypass.
  - Empty with a simultaneous push: the entry becomes poppable the next cycle, with no bypass.
- Result accept: `result_ready = (count != 0) & (skid not FULL)`. A result handshake pops exactly one divisor; pairing is strictly in order.
- Adjustment, with `d` = popped divisor, `q` = `quotient_in`, `r` = `remainder_in`:
  - If `divide_by_zero_in` = 1: pass `q`, `r` and the flag unchanged; `adjusted` = 0.
  - Else if `r != 0` and `r[W-1] != d[W-1]`: quotient = `q - 1`, remainder = `r + d`, `adjusted` = 1.
  - Else: pass `q` and `r` unchanged; `adjusted` = 0.
  - All arithmetic is modulo 2^`WORD_WIDTH` (wraps, no saturation). The most-negative quotient minus 1 wraps to the most-positive value.
- Output skid buffer, states:
  - EMPTY: nothing held; `output_valid` = 0.
  - BUSY: main register valid.
  - FULL: main and skid registers valid.
- Skid transitions:
  - EMPTY→BUSY on accept.
  - BUSY→EMPTY on output handshake with no accept.
  - BUSY stays BUSY on simultaneous accept and output handshake, with main reloaded.
  - BUSY→FULL on accept without output handshake; the new word goes to skid.
  - FULL→BUSY on output handshake; skid moves to main.
  - FULL never accepts.
- Output data changes only on an output handshake or while `output_valid` = 0; it is stable while stalled.

## Timing

- Reset (`clear_n` low, asynchronous) forces:
  - FIFO empty; skid EMPTY.
  - `divisor_ready` = 1, `result_ready` = 0, `output_valid` = 0.
  - `quotient`, `remainder`, `divide_by_zero`, `adjusted` = 0.
- Deassertion is synchronised externally. A reset mid-operation discards all queued divisors and held results.
- Latency: 1 cycle from the result handshake to `output_valid`.
- Throughput: 1 result per cycle when `output_ready` stays high.
- First result: accepted no earlier than 1 cycle after its divisor push.
- No combinational path from `output_ready` to `result_ready` or `divisor_ready`, or from any input valid to any output.

## Test plan

- **Signed cases** (`WORD_WIDTH`=8). Push divisors 7, 7, −7, −7, 7. Feed (3,1), (−3,−1), (−3,1), (3,−1), (−3,0). Required output:
  - (3,1), adjusted=0
  - (−4,6), adjusted=1
  - (−4,−6), adjusted=1
  - (3,−1), adjusted=0
  - (−3,0), adjusted=0
- **Divide by zero.** Push divisor 0. Feed `q`=−1, `r`=22, dbz=1. Required output: −1, 22, dbz=1, adjusted=0; the FIFO count returns to 0.
- **Backpressure.** Hold `output_ready`=0 and stream 3 results.
  - Two are accepted: skid goes FULL and `result_ready` drops.
  - On release, outputs appear in order, one per cycle, and data stays stable while stalled.
- **FIFO limits** (`FIFO_DEPTH`=4). Push 4 divisors: `divisor_ready`=0 on the 5th. Push and pop simultaneously while full: the push is refused. Pop all: `result_ready`=0 when empty.
- **Wrap.** Divisor 127, `q`=−128, `r`=−1 → quotient 127 (wrapped), remainder 126, adjusted=1.
- **Async reset.** Drop `clear_n` mid-stream, between clock edges, with skid FULL and 3 divisors queued.
  - All outputs go to reset values immediately.
  - After release, a fresh divisor/result pair completes correctly.
